trdb_apb_initiator: RTL and testbench
=====================================

Name: trdb_apb_initiator

Overview:
- Initiator for the trace debugger's memory-mapped peripheral register port (per_* bus).
- Converts single-beat requests (addr/wdata/we, valid/ready) from a debug-module or test-harness sequencer into exactly one per_valid access.
- Returns read data or an error via a valid/ready response channel.
- Lets on-chip logic program ctrl/filter/address registers and push dump words without a CPU.

Parameters:
- APB_ADDR_WIDTH, 12, width of per_addr_o / req_addr_i.
- TIMEOUT_CYCLES, 16, max ACCESS cycles waiting on per_ready_i (used only with timeout feature).
- TIMEOUT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted (IDLE only).
- req_addr_i  in  APB_ADDR_WIDTH  register address.
- req_wdata_i  in  32  write data.
- req_we_i  in  1  1=write, 0=read.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  access timed out.
- per_valid_o  out  1  access strobe to register block.
- per_we_o  out  1  write enable.
- per_addr_o  out  APB_ADDR_WIDTH  address.
- per_wdata_o  out  32  write data.
- per_rdata_i  in  32  read data; valid while per_valid_o & ~per_we_o.
- per_ready_i  in  1  access complete.

Behaviour:
- Single clock domain on clk_i.
- rst_i is synchronous and active-high; sampled only at posedge clk_i.
- Reset state is IDLE. Reset values: per_valid_o=0, per_we_o=0, per_addr_o=0, per_wdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0.
- req_ready_o=1 in IDLE and is combinational on state.
- IDLE: req_valid_i & req_ready_o -> latch addr/wdata/we into the per_* output regs; next state ACCESS.
- ACCESS:
  - per_valid_o=1; per_addr_o, per_we_o, per_wdata_o stable for the whole state.
  - On per_ready_i=1: capture rsp_rdata_o = per_we_o ? 0 : per_rdata_i; rsp_err_o=0; next state RESP.
  - per_valid_o drops at that same edge, so the register block sees exactly one strobe cycle when per_ready_i=1. This is mandatory: every cycle of a dump write strobe pushes a software FIFO entry.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable.
  - On rsp_ready_i -> IDLE.
  - New requests are not accepted in RESP (req_ready_o=0).
- Latency (per_ready_i and rsp_ready_i held high): request accepted at edge 0, per_valid_o high in cycle 1, rsp_valid_o high in cycle 2, back in IDLE in cycle 3. Throughput is one transaction per 3 cycles.
- Backpressure:
  - per_ready_i low: stay in ACCESS with all outputs constant.
  - rsp_ready_i low: stay in RESP indefinitely.
- A request arriving outside IDLE is ignored; the requester must hold req_valid_i.
- rst_i asserted in any state: IDLE at the next edge, all outputs take their reset values, any in-flight transaction is dropped with no response.
- No output is combinationally dependent on per_* inputs.

Optional Feature:
- Macro: TRDB_APB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle with per_ready_i=0.
  - When the count reaches TIMEOUT_CYCLES with per_ready_i still 0: drop per_valid_o, go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - If per_ready_i=1 in that same cycle, the normal completion wins.
- Undefined: no counter; ACCESS waits forever; rsp_err_o tied 0.

Decomposition:
- trdb_pkg gains:
  - enum trdb_apb_state_e {TRDB_APB_IDLE, TRDB_APB_ACCESS, TRDB_APB_RESP}.
  - Constant TRDB_APB_TIMEOUT_DEFAULT=16.
- Register addresses (REG_TRDB_*) are reused from trdb_pkg.
- Single module; no sub-module is warranted.

Test Plan:
- Write, REG_TRDB_CTRL, wdata 0x0000_0003, per_ready_i=1 -> per_valid_o/per_we_o high for exactly 1 cycle (cycle 1), rsp_valid_o in cycle 2, rsp_rdata_o=0, rsp_err_o=0.
- Read, REG_TRDB_FILTER, per_rdata_i=0x0000_0045 -> rsp_rdata_o=0x45 in cycle 2; per_we_o=0 throughout.
- per_ready_i low 5 cycles, then high -> per_valid_o high for 6 cycles with addr/wdata constant; a single response follows.
- rsp_ready_i low 4 cycles in RESP, with req_valid_i high for a second request -> req_ready_o=0 and rsp data stable until the handshake; second access starts afterwards.
- rst_i asserted during ACCESS -> next cycle per_valid_o=0, rsp_valid_o=0, state IDLE, req_ready_o=1; no response emitted.
- TRDB_APB_TIMEOUT_EN defined, per_ready_i held 0 -> per_valid_o drops after 16 cycles; rsp_err_o=1, rsp_rdata_o=0.

Source files
------------

// File: rtl/trdb_pkg.sv
// trdb_pkg: shared trace-debugger types, register map and defaults
package trdb_pkg;
    typedef enum logic [1:0] {
        TRDB_APB_IDLE,
        TRDB_APB_ACCESS,
        TRDB_APB_RESP
    } trdb_apb_state_e;

    localparam int TRDB_APB_TIMEOUT_DEFAULT = 16;

    localparam logic [11:0] REG_TRDB_CTRL       = 12'h000;
    localparam logic [11:0] REG_TRDB_STATUS     = 12'h004;
    localparam logic [11:0] REG_TRDB_FILTER     = 12'h008;
    localparam logic [11:0] REG_TRDB_ADDR_LOW   = 12'h00c;
    localparam logic [11:0] REG_TRDB_ADDR_HIGH  = 12'h010;
    localparam logic [11:0] REG_TRDB_DUMP       = 12'h014;
    localparam logic [11:0] REG_TRDB_DUMP_WITH_TIME = 12'h018;
endpackage

// File: rtl/trdb_apb_initiator.sv
// trdb_apb_initiator: single-beat req/rsp to per_* bus bridge; access timeout enabled by TRDB_APB_TIMEOUT_EN
module trdb_apb_initiator
    import trdb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = TRDB_APB_TIMEOUT_DEFAULT,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_we_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      per_valid_o,
    output logic                      per_we_o,
    output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
    output logic [31:0]               per_wdata_o,
    input  logic [31:0]               per_rdata_i,
    input  logic                      per_ready_i
);
    trdb_apb_state_e state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic we_q, we_d, err_q, err_d;
    logic timeout;
`ifdef TRDB_APB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    assign timeout = cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == TRDB_APB_IDLE) cnt_d = '0;
        else if (state_q == TRDB_APB_ACCESS && !per_ready_i) cnt_d = cnt_q + 1'b1;
    end
    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
`else
    assign timeout = 1'b0;
`endif
    assign req_ready_o = state_q == TRDB_APB_IDLE;
    assign per_valid_o = state_q == TRDB_APB_ACCESS;
    assign rsp_valid_o = state_q == TRDB_APB_RESP;
    assign per_we_o    = we_q;
    assign per_addr_o  = addr_q;
    assign per_wdata_o = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            TRDB_APB_IDLE: if (req_valid_i) begin
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                we_d    = req_we_i;
                state_d = TRDB_APB_ACCESS;
            end
            TRDB_APB_ACCESS: if (per_ready_i || timeout) begin
                // a completion in the timeout cycle still wins over the error
                rdata_d = (per_ready_i && !we_q) ? per_rdata_i : '0;
                err_d   = !per_ready_i;
                state_d = TRDB_APB_RESP;
            end
            TRDB_APB_RESP: state_d = rsp_ready_i ? TRDB_APB_IDLE : TRDB_APB_RESP;
            default: state_d = TRDB_APB_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TRDB_APB_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_trdb_apb_initiator.sv
// tb_trdb_apb_initiator: directed checks of the per_* bus initiator
module tb_trdb_apb_initiator;
    import trdb_pkg::*;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b1, per_ready_i = 1'b1;
    logic [11:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0, per_rdata_i = '0;
    logic req_ready_o, rsp_valid_o, rsp_err_o, per_valid_o, per_we_o;
    logic [11:0] per_addr_o;
    logic [31:0] rsp_rdata_o, per_wdata_o;
    int checks = 0, errors = 0;

    trdb_apb_initiator dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .per_valid_o(per_valid_o), .per_we_o(per_we_o), .per_addr_o(per_addr_o),
        .per_wdata_o(per_wdata_o), .per_rdata_i(per_rdata_i), .per_ready_i(per_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [11:0] a, input logic [31:0] d, input logic we);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_wdata_i = d;
        req_we_i    = we;
    endtask

    initial begin
        step();
        step();
        rst_i = 1'b0;
        chk("rst_per_valid", per_valid_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_per_addr", per_addr_o, 0);
        chk("rst_per_we", per_we_o, 0);
        chk("rst_per_wdata", per_wdata_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_err", rsp_err_o, 0);

        // write CTRL, zero-wait
        per_rdata_i = 32'hdead_beef;
        req(REG_TRDB_CTRL, 32'h0000_0003, 1'b1);
        step();
        req_valid_i = 1'b0;
        chk("wr_c1_per_valid", per_valid_o, 1);
        chk("wr_c1_per_we", per_we_o, 1);
        chk("wr_c1_addr", per_addr_o, REG_TRDB_CTRL);
        chk("wr_c1_wdata", per_wdata_o, 32'h3);
        chk("wr_c1_req_ready", req_ready_o, 0);
        chk("wr_c1_rsp_valid", rsp_valid_o, 0);
        step();
        chk("wr_c2_per_valid", per_valid_o, 0);
        chk("wr_c2_rsp_valid", rsp_valid_o, 1);
        chk("wr_c2_rdata", rsp_rdata_o, 0);
        chk("wr_c2_err", rsp_err_o, 0);
        step();
        chk("wr_c3_rsp_valid", rsp_valid_o, 0);
        chk("wr_c3_req_ready", req_ready_o, 1);

        // read FILTER
        per_rdata_i = 32'h0000_0045;
        req(REG_TRDB_FILTER, 32'h1234_5678, 1'b0);
        step();
        req_valid_i = 1'b0;
        chk("rd_c1_per_valid", per_valid_o, 1);
        chk("rd_c1_per_we", per_we_o, 0);
        chk("rd_c1_addr", per_addr_o, REG_TRDB_FILTER);
        step();
        chk("rd_c2_rsp_valid", rsp_valid_o, 1);
        chk("rd_c2_rdata", rsp_rdata_o, 32'h45);
        chk("rd_c2_per_we", per_we_o, 0);
        step();

        // per_ready low for 5 cycles
        per_ready_i = 1'b0;
        req(12'h010, 32'ha5a5_5a5a, 1'b1);
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) per_ready_i = 1'b1;
            chk($sformatf("wait_per_valid_%0d", i), per_valid_o, 1);
            chk($sformatf("wait_addr_%0d", i), per_addr_o, 12'h010);
            chk($sformatf("wait_wdata_%0d", i), per_wdata_o, 32'ha5a5_5a5a);
            chk($sformatf("wait_rsp_valid_%0d", i), rsp_valid_o, 0);
            step();
        end
        chk("wait_done_per_valid", per_valid_o, 0);
        chk("wait_done_rsp_valid", rsp_valid_o, 1);
        step();
        chk("wait_idle_rsp_valid", rsp_valid_o, 0);

        // rsp backpressure with a second request held pending
        rsp_ready_i = 1'b0;
        per_rdata_i = 32'h0000_0077;
        req(REG_TRDB_FILTER, 32'h0, 1'b0);
        step();
        req(REG_TRDB_CTRL, 32'h0000_0001, 1'b1);
        chk("bp_c1_per_valid", per_valid_o, 1);
        step();
        per_rdata_i = 32'h0000_0099;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_rsp_valid_%0d", i), rsp_valid_o, 1);
            chk($sformatf("bp_rdata_%0d", i), rsp_rdata_o, 32'h77);
            chk($sformatf("bp_req_ready_%0d", i), req_ready_o, 0);
            chk($sformatf("bp_per_valid_%0d", i), per_valid_o, 0);
            step();
        end
        rsp_ready_i = 1'b1;
        chk("bp_last_rsp_valid", rsp_valid_o, 1);
        chk("bp_last_rdata", rsp_rdata_o, 32'h77);
        step();
        chk("bp_idle_req_ready", req_ready_o, 1);
        chk("bp_idle_rsp_valid", rsp_valid_o, 0);
        step();
        req_valid_i = 1'b0;
        chk("bp_2nd_per_valid", per_valid_o, 1);
        chk("bp_2nd_addr", per_addr_o, REG_TRDB_CTRL);
        chk("bp_2nd_we", per_we_o, 1);
        step();
        chk("bp_2nd_rsp_valid", rsp_valid_o, 1);
        chk("bp_2nd_rdata", rsp_rdata_o, 0);
        step();

        // reset mid-access drops the transaction
        per_ready_i = 1'b0;
        req(12'h020, 32'hcafe_f00d, 1'b1);
        step();
        req_valid_i = 1'b0;
        chk("rs_c1_per_valid", per_valid_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rs_per_valid", per_valid_o, 0);
        chk("rs_rsp_valid", rsp_valid_o, 0);
        chk("rs_req_ready", req_ready_o, 1);
        chk("rs_per_addr", per_addr_o, 0);
        chk("rs_per_we", per_we_o, 0);
        per_ready_i = 1'b1;
        step();
        chk("rs_no_rsp_a", rsp_valid_o, 0);
        step();
        chk("rs_no_rsp_b", rsp_valid_o, 0);
        chk("rs_no_access", per_valid_o, 0);

`ifdef TRDB_APB_TIMEOUT_EN
        per_ready_i = 1'b0;
        per_rdata_i = 32'h0000_1111;
        req(REG_TRDB_STATUS, 32'h0, 1'b0);
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_per_valid_%0d", i), per_valid_o, 1);
            step();
        end
        chk("to_per_valid_drop", per_valid_o, 0);
        chk("to_rsp_valid", rsp_valid_o, 1);
        chk("to_err", rsp_err_o, 1);
        chk("to_rdata", rsp_rdata_o, 0);
        per_ready_i = 1'b1;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
